// File: rtl/rocc_cmd_issuer_if.sv
// RoCC command/response channel between the core-side issuer (master) and an accelerator (slave).
interface rocc_cmd_issuer_if #(
  parameter int xLen = 64
);
  logic            rocc_cmd_valid;
  logic            rocc_cmd_ready;
  logic [31:0]     rocc_cmd_bits_inst;
  logic [xLen-1:0] rocc_cmd_bits_rs1;
  logic [xLen-1:0] rocc_cmd_bits_rs2;
  logic            rocc_resp_valid;
  logic            rocc_resp_ready;
  logic [4:0]      rocc_resp_bits_rd;
  logic [xLen-1:0] rocc_resp_bits_data;

  modport master (
    output rocc_cmd_valid, rocc_cmd_bits_inst, rocc_cmd_bits_rs1, rocc_cmd_bits_rs2, rocc_resp_ready,
    input  rocc_cmd_ready, rocc_resp_valid, rocc_resp_bits_rd, rocc_resp_bits_data
  );

  modport slave (
    input  rocc_cmd_valid, rocc_cmd_bits_inst, rocc_cmd_bits_rs1, rocc_cmd_bits_rs2, rocc_resp_ready,
    output rocc_cmd_ready, rocc_resp_valid, rocc_resp_bits_rd, rocc_resp_bits_data
  );
endinterface

// File: rtl/rocc_cmd_issuer.sv
// Core-side RoCC initiator: command FIFO, rd scoreboard for xd=1 commands, registered write-back,
// fence drain FSM, response timeout and unexpected-response detection.
module rocc_cmd_issuer #(
  parameter int xLen      = 64,
  parameter int CMD_DEPTH = 4,
  parameter int MAX_OUTST = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            host_valid,
  output logic            host_ready,
  input  logic [31:0]     host_inst,
  input  logic [xLen-1:0] host_rs1,
  input  logic [xLen-1:0] host_rs2,
  input  logic            fence_valid,
  output logic            fence_done,
  rocc_cmd_issuer_if.master rocc,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [xLen-1:0] wb_data,
  output logic [5:0]      outstanding,
  output logic            busy,
  output logic            err_unexpected,
  output logic            err_timeout
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {RUN, FENCE} state_t;

  logic [31:0]     inst_mem [CMD_DEPTH];
  logic [xLen-1:0] rs1_mem  [CMD_DEPTH];
  logic [xLen-1:0] rs2_mem  [CMD_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     pending, pending_next;
  logic [TW-1:0]   timer;
  state_t          state, state_next;
  logic            fence_done_next;

  logic        empty, full, push, issue, track, stall;
  logic        resp_hit, resp_miss;
  logic [31:0] head_inst;
  logic        head_xd;
  logic [4:0]  head_rd;

  assign empty     = (count == '0);
  assign full      = (count == CW'(CMD_DEPTH));
  assign head_inst = inst_mem[rd_ptr];
  assign head_xd   = head_inst[14];
  assign head_rd   = head_inst[11:7];

  // Stall terms depend only on registered state and the unchanged head, so valid cannot drop before ready.
  assign stall = head_xd && (pending[head_rd] || (outstanding == 6'(MAX_OUTST)));

  assign host_ready               = !full && (state == RUN);
  assign rocc.rocc_cmd_valid      = !empty && !stall;
  assign rocc.rocc_cmd_bits_inst  = empty ? '0 : head_inst;
  assign rocc.rocc_cmd_bits_rs1   = empty ? '0 : rs1_mem[rd_ptr];
  assign rocc.rocc_cmd_bits_rs2   = empty ? '0 : rs2_mem[rd_ptr];
  assign rocc.rocc_resp_ready     = 1'b1;

  assign push      = host_valid && host_ready;
  assign issue     = rocc.rocc_cmd_valid && rocc.rocc_cmd_ready;
  assign track     = issue && head_xd;
  assign resp_hit  = rocc.rocc_resp_valid && pending[rocc.rocc_resp_bits_rd];
  assign resp_miss = rocc.rocc_resp_valid && !pending[rocc.rocc_resp_bits_rd];
  assign busy      = !empty || (outstanding != '0);

  // NOTE: payload storage has no reset; empty gates the head outputs so stale entries never escape.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= host_inst;
      rs1_mem[wr_ptr]  <= host_rs1;
      rs2_mem[wr_ptr]  <= host_rs2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(issue);
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    pending_next = pending;
    if (resp_hit) pending_next[rocc.rocc_resp_bits_rd] = 1'b0;
    if (track)    pending_next[head_rd] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending        <= '0;
      outstanding    <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      err_unexpected <= 1'b0;
    end else begin
      pending     <= pending_next;
      outstanding <= outstanding + 6'(track) - 6'(resp_hit);
      wb_valid    <= resp_hit;
      if (resp_hit) begin
        wb_rd   <= rocc.rocc_resp_bits_rd;
        wb_data <= rocc.rocc_resp_bits_data;
      end
      if (resp_miss) err_unexpected <= 1'b1;
    end
  end

  // Timer counts idle cycles while responses are owed; it saturates once the error is flagged.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer       <= '0;
      err_timeout <= 1'b0;
    end else if (rocc.rocc_resp_valid || (outstanding == '0)) begin
      timer <= '0;
    end else if (timer == TW'(TIMEOUT - 1)) begin
      err_timeout <= 1'b1;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_comb begin
    state_next      = state;
    fence_done_next = 1'b0;
    case (state)
      RUN:   if (fence_valid) state_next = FENCE;
      FENCE: if (empty && (outstanding == '0)) begin
        state_next      = RUN;
        fence_done_next = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      fence_done <= 1'b0;
    end else begin
      state      <= state_next;
      fence_done <= fence_done_next;
    end
  end
endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Directed bench for rocc_cmd_issuer: inputs change and outputs are sampled on the falling clock edge.
module tb_rocc_cmd_issuer;
  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            host_valid = 1'b0;
  logic            host_ready;
  logic [31:0]     host_inst = '0;
  logic [XLEN-1:0] host_rs1 = '0;
  logic [XLEN-1:0] host_rs2 = '0;
  logic            fence_valid = 1'b0;
  logic            fence_done;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [5:0]      outstanding;
  logic            busy;
  logic            err_unexpected;
  logic            err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rocc_cmd_issuer_if #(.xLen(XLEN)) rocc ();

  rocc_cmd_issuer #(.xLen(XLEN), .CMD_DEPTH(4), .MAX_OUTST(8), .TIMEOUT(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_inst      (host_inst),
    .host_rs1       (host_rs1),
    .host_rs2       (host_rs2),
    .fence_valid    (fence_valid),
    .fence_done     (fence_done),
    .rocc           (rocc),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .outstanding    (outstanding),
    .busy           (busy),
    .err_unexpected (err_unexpected),
    .err_timeout    (err_timeout)
  );

  function automatic logic [31:0] mk_inst(input logic xd, input logic [4:0] rd);
    return {7'h01, 5'd2, 5'd1, xd, 1'b1, 1'b1, rd, 7'h0b};
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    host_valid                = 1'b0;
    fence_valid               = 1'b0;
    rocc.rocc_cmd_ready       = 1'b0;
    rocc.rocc_resp_valid      = 1'b0;
    rocc.rocc_resp_bits_rd    = '0;
    rocc.rocc_resp_bits_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic respond(input logic [4:0] rd, input logic [XLEN-1:0] data);
    rocc.rocc_resp_valid     = 1'b1;
    rocc.rocc_resp_bits_rd   = rd;
    rocc.rocc_resp_bits_data = data;
    tick();
    rocc.rocc_resp_valid     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready: got %b want 1", host_ready); end
    checks++; if (rocc.rocc_resp_ready !== 1'b1) begin errors++; $display("FAIL reset_resp_ready: got %b want 1", rocc.rocc_resp_ready); end
    checks++; if (rocc.rocc_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", rocc.rocc_cmd_valid); end
    checks++; if (rocc.rocc_cmd_bits_inst !== 32'h0) begin errors++; $display("FAIL reset_cmd_inst: got %h want 0", rocc.rocc_cmd_bits_inst); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (outstanding !== 6'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({err_unexpected, err_timeout, fence_done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {err_unexpected, err_timeout, fence_done}); end
    reset = 1'b0;
  endtask

  // One xd=1 command, response two cycles after issue, write-back one cycle after the response.
  task automatic test_single();
    rocc.rocc_cmd_ready = 1'b1;
    host_valid = 1'b1; host_inst = mk_inst(1'b1, 5'd5); host_rs1 = 64'd3; host_rs2 = 64'd4;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL t1_host_ready: got %b want 1", host_ready); end
    tick();
    host_valid = 1'b0;
    checks++; if (rocc.rocc_cmd_valid !== 1'b1) begin errors++; $display("FAIL t1_cmd_valid: got %b want 1", rocc.rocc_cmd_valid); end
    checks++; if (rocc.rocc_cmd_bits_inst !== mk_inst(1'b1, 5'd5)) begin errors++; $display("FAIL t1_cmd_inst: got %h want %h", rocc.rocc_cmd_bits_inst, mk_inst(1'b1, 5'd5)); end
    checks++; if (rocc.rocc_cmd_bits_rs1 !== 64'd3 || rocc.rocc_cmd_bits_rs2 !== 64'd4) begin errors++; $display("FAIL t1_cmd_ops: got %0d/%0d want 3/4", rocc.rocc_cmd_bits_rs1, rocc.rocc_cmd_bits_rs2); end
    checks++; if (outstanding !== 6'd0) begin errors++; $display("FAIL t1_outst_pre: got %0d want 0", outstanding); end
    tick();
    checks++; if (outstanding !== 6'd1) begin errors++; $display("FAIL t1_outst_issued: got %0d want 1", outstanding); end
    checks++; if (rocc.rocc_cmd_valid !== 1'b0) begin errors++; $display("FAIL t1_cmd_drained: got %b want 0", rocc.rocc_cmd_valid); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL t1_wb_early: got %b want 0", wb_valid); end
    respond(5'd5, 64'h7);
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'h7) begin errors++; $display("FAIL t1_wb: got v=%b rd=%0d d=%h want v=1 rd=5 d=7", wb_valid, wb_rd, wb_data); end
    checks++; if (outstanding !== 6'd0) begin errors++; $display("FAIL t1_outst_done: got %0d want 0", outstanding); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL t1_wb_pulse: got %b want 0", wb_valid); end
  endtask

  // Same rd twice: the second waits on the registered scoreboard.
  task automatic test_same_rd();
    rocc.rocc_cmd_ready = 1'b1;
    host_valid = 1'b1; host_inst = mk_inst(1'b1, 5'd7); host_rs1 = 64'd1;
    tick();
    host_rs1 = 64'd2;
    tick();
    host_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rocc.rocc_cmd_valid !== 1'b0 || outstanding !== 6'd1) begin errors++; $display("FAIL t2_held_%0d: got v=%b outst=%0d want v=0 outst=1", i, rocc.rocc_cmd_valid, outstanding); end
      tick();
    end
    checks++; if (rocc.rocc_cmd_bits_rs1 !== 64'd2) begin errors++; $display("FAIL t2_head: got %0d want 2", rocc.rocc_cmd_bits_rs1); end
    rocc.rocc_resp_valid = 1'b1; rocc.rocc_resp_bits_rd = 5'd7; rocc.rocc_resp_bits_data = 64'hA;
    checks++; if (rocc.rocc_cmd_valid !== 1'b0) begin errors++; $display("FAIL t2_same_cycle: got %b want 0", rocc.rocc_cmd_valid); end
    tick();
    rocc.rocc_resp_valid = 1'b0;
    checks++; if (rocc.rocc_cmd_valid !== 1'b1 || outstanding !== 6'd0) begin errors++; $display("FAIL t2_release: got v=%b outst=%0d want v=1 outst=0", rocc.rocc_cmd_valid, outstanding); end
    tick();
    checks++; if (outstanding !== 6'd1 || busy !== 1'b1) begin errors++; $display("FAIL t2_second: got outst=%0d busy=%b want 1/1", outstanding, busy); end
    respond(5'd7, 64'hB);
    checks++; if (outstanding !== 6'd0 || wb_data !== 64'hB) begin errors++; $display("FAIL t2_done: got outst=%0d d=%h want 0/b", outstanding, wb_data); end
  endtask

  // Fill the FIFO with the accelerator stalled, check backpressure, ordering and pointer wrap.
  task automatic test_fifo_full();
    rocc.rocc_cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_valid = 1'b1; host_inst = mk_inst(1'b0, 5'(i + 1)); host_rs1 = XLEN'(10 + i);
      checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_%0d: got %b want 1", i, host_ready); end
      tick();
    end
    host_rs1 = 64'd99;
    checks++; if (host_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t3_full: got ready=%b busy=%b want 0/1", host_ready, busy); end
    tick();
    host_valid = 1'b0;
    rocc.rocc_cmd_ready = 1'b1;
    checks++; if (rocc.rocc_cmd_bits_rs1 !== 64'd10) begin errors++; $display("FAIL t3_head0: got %0d want 10", rocc.rocc_cmd_bits_rs1); end
    tick();
    rocc.rocc_cmd_ready = 1'b0;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL t3_reopen: got %b want 1", host_ready); end
    rocc.rocc_cmd_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++; if (rocc.rocc_cmd_bits_rs1 !== XLEN'(10 + i)) begin errors++; $display("FAIL t3_order_%0d: got %0d want %0d", i, rocc.rocc_cmd_bits_rs1, 10 + i); end
      tick();
    end
    rocc.rocc_cmd_ready = 1'b0;
    checks++; if (busy !== 1'b0 || outstanding !== 6'd0 || rocc.rocc_cmd_valid !== 1'b0) begin errors++; $display("FAIL t3_drained: got busy=%b outst=%0d v=%b want 0/0/0", busy, outstanding, rocc.rocc_cmd_valid); end
  endtask

  task automatic test_unexpected();
    respond(5'd9, 64'h55);
    checks++; if (err_unexpected !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL t4_flag: got err=%b wb=%b want 1/0", err_unexpected, wb_valid); end
    tick();
    tick();
    checks++; if (err_unexpected !== 1'b1 || outstanding !== 6'd0) begin errors++; $display("FAIL t4_sticky: got err=%b outst=%0d want 1/0", err_unexpected, outstanding); end
    do_reset();
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL t4_reset_clear: got %b want 0", err_unexpected); end
  endtask

  // Eight distinct rds fill the scoreboard; the ninth waits for one response.
  task automatic test_max_outst();
    do_reset();
    rocc.rocc_cmd_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      host_valid = 1'b1; host_inst = mk_inst(1'b1, 5'(i)); host_rs1 = XLEN'(i);
      checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL mo_ready_%0d: got %b want 1", i, host_ready); end
      tick();
    end
    host_valid = 1'b0;
    checks++; if (outstanding !== 6'd8 || rocc.rocc_cmd_valid !== 1'b0) begin errors++; $display("FAIL mo_cap: got outst=%0d v=%b want 8/0", outstanding, rocc.rocc_cmd_valid); end
    checks++; if (rocc.rocc_cmd_bits_rs1 !== 64'd9) begin errors++; $display("FAIL mo_head: got %0d want 9", rocc.rocc_cmd_bits_rs1); end
    respond(5'd1, 64'd3);
    checks++; if (rocc.rocc_cmd_valid !== 1'b1 || outstanding !== 6'd7 || wb_rd !== 5'd1) begin errors++; $display("FAIL mo_release: got v=%b outst=%0d rd=%0d want 1/7/1", rocc.rocc_cmd_valid, outstanding, wb_rd); end
    tick();
    rocc.rocc_cmd_ready = 1'b0;
    checks++; if (outstanding !== 6'd8) begin errors++; $display("FAIL mo_refill: got %0d want 8", outstanding); end
    for (int i = 2; i <= 9; i++) respond(5'(i), XLEN'(i * 3));
    checks++; if (outstanding !== 6'd0 || busy !== 1'b0 || wb_data !== 64'd27) begin errors++; $display("FAIL mo_drain: got outst=%0d busy=%b d=%0d want 0/0/27", outstanding, busy, wb_data); end
    checks++; if (err_unexpected !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL mo_errs: got %b%b want 00", err_unexpected, err_timeout); end
  endtask

  task automatic test_timeout();
    do_reset();
    rocc.rocc_cmd_ready = 1'b1;
    host_valid = 1'b1; host_inst = mk_inst(1'b1, 5'd2);
    tick();
    host_valid = 1'b0;
    tick();
    rocc.rocc_cmd_ready = 1'b0;
    checks++; if (outstanding !== 6'd1) begin errors++; $display("FAIL t5_issued: got %0d want 1", outstanding); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL t5_early: got %b want 0 at cycle 15", err_timeout); end
      end
      if (k == 16) begin
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL t5_fire: got %b want 1 at cycle 16", err_timeout); end
      end
    end
    respond(5'd2, 64'h0);
    checks++; if (err_timeout !== 1'b1 || outstanding !== 6'd0 || wb_valid !== 1'b1) begin errors++; $display("FAIL t5_sticky: got err=%b outst=%0d wb=%b want 1/0/1", err_timeout, outstanding, wb_valid); end
  endtask

  task automatic test_fence_reset();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      host_valid = 1'b1; host_inst = mk_inst(1'b1, 5'(i));
      tick();
    end
    host_valid = 1'b0;
    fence_valid = 1'b1;
    tick();
    fence_valid = 1'b0;
    checks++; if (host_ready !== 1'b0 || fence_done !== 1'b0) begin errors++; $display("FAIL t6_fence_enter: got ready=%b done=%b want 0/0", host_ready, fence_done); end
    rocc.rocc_cmd_ready = 1'b1;
    tick(); tick(); tick();
    rocc.rocc_cmd_ready = 1'b0;
    checks++; if (outstanding !== 6'd3 || host_ready !== 1'b0) begin errors++; $display("FAIL t6_issued: got outst=%0d ready=%b want 3/0", outstanding, host_ready); end
    respond(5'd1, 64'h1);
    respond(5'd2, 64'h2);
    respond(5'd3, 64'h3);
    checks++; if (outstanding !== 6'd0 || fence_done !== 1'b0 || host_ready !== 1'b0) begin errors++; $display("FAIL t6_last_resp: got outst=%0d done=%b ready=%b want 0/0/0", outstanding, fence_done, host_ready); end
    tick();
    checks++; if (fence_done !== 1'b1 || host_ready !== 1'b1) begin errors++; $display("FAIL t6_done: got done=%b ready=%b want 1/1", fence_done, host_ready); end
    tick();
    checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL t6_done_pulse: got %b want 0", fence_done); end
    fence_valid = 1'b1;
    tick();
    fence_valid = 1'b0;
    checks++; if (fence_done !== 1'b0 || host_ready !== 1'b0) begin errors++; $display("FAIL t6_idle_enter: got done=%b ready=%b want 0/0", fence_done, host_ready); end
    tick();
    checks++; if (fence_done !== 1'b1) begin errors++; $display("FAIL t6_idle_done: got %b want 1", fence_done); end
    rocc.rocc_cmd_ready = 1'b1;
    host_valid = 1'b1; host_inst = mk_inst(1'b1, 5'd4);
    tick();
    host_inst = mk_inst(1'b1, 5'd5);
    tick();
    host_valid = 1'b0;
    checks++; if (outstanding !== 6'd1 || busy !== 1'b1) begin errors++; $display("FAIL t6_midstream: got outst=%0d busy=%b want 1/1", outstanding, busy); end
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    checks++; if (outstanding !== 6'd0 || busy !== 1'b0) begin errors++; $display("FAIL t6_reset: got outst=%0d busy=%b want 0/0", outstanding, busy); end
    respond(5'd4, 64'h4);
    checks++; if (err_unexpected !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL t6_stale_resp: got err=%b wb=%b want 1/0", err_unexpected, wb_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, limit 100000", $time);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_same_rd();
    test_fifo_full();
    test_unexpected();
    test_max_outst();
    test_timeout();
    test_fence_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
